// File: rtl/booth8_pkg.sv
// -----------------------------------------------------------------------------
// booth8_pkg
// Shared definitions for the pipelined radix-8 Booth multiplier.
//   booth_sel_t : one-hot magnitude select {1,2,3,4}Y plus negate flag
//   nd()        : number of radix-8 digits needed for a W-bit operand
//   booth8_enc(): recodes one 4-bit window x'[3i+2:3i-1] into a select struct
// -----------------------------------------------------------------------------
package booth8_pkg;

    typedef struct packed {
        logic sel_one;
        logic sel_two;
        logic sel_three;
        logic sel_four;
        logic neg;
    } booth_sel_t;

    // Digits for a (W+1)-bit extended operand: ceil((W+1)/3).
    function automatic int nd(input int w);
        return (w + 3) / 3;
    endfunction

    // Window bits {b3,b2,b1,b0}; digit value = -4*b3 + 2*b2 + b1 + b0.
    // Both zero windows (0000 and 1111) select nothing and carry no negate,
    // so they contribute neither a partial product nor a correction bit.
    function automatic booth_sel_t booth8_enc(input logic [3:0] b);
        booth_sel_t s;
        s = '0;
        case (b)
            4'b0001, 4'b0010: s.sel_one   = 1'b1;
            4'b0011, 4'b0100: s.sel_two   = 1'b1;
            4'b0101, 4'b0110: s.sel_three = 1'b1;
            4'b0111:          s.sel_four  = 1'b1;
            4'b1000:          begin s.sel_four  = 1'b1; s.neg = 1'b1; end
            4'b1001, 4'b1010: begin s.sel_three = 1'b1; s.neg = 1'b1; end
            4'b1011, 4'b1100: begin s.sel_two   = 1'b1; s.neg = 1'b1; end
            4'b1101, 4'b1110: begin s.sel_one   = 1'b1; s.neg = 1'b1; end
            default:          s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/booth8_pp_gen.sv
// -----------------------------------------------------------------------------
// booth8_pp_gen
// One radix-8 Booth partial product, unshifted, at 2W width.
//   i_sel          : digit select struct from booth8_enc()
//   i_y1..i_y4     : Y', 2Y', 3Y', 4Y' sign/zero-extended to 2W bits
//   o_pp           : selected multiple, one's-complemented when negative
//   o_corr         : +1 correction completing the two's-complement negate
// -----------------------------------------------------------------------------
module booth8_pp_gen
    import booth8_pkg::*;
#(
    parameter int W = 8
) (
    input  booth_sel_t     i_sel,
    input  logic [2*W-1:0] i_y1,
    input  logic [2*W-1:0] i_y2,
    input  logic [2*W-1:0] i_y3,
    input  logic [2*W-1:0] i_y4,
    output logic [2*W-1:0] o_pp,
    output logic           o_corr
);

    logic [2*W-1:0] w_mag;

    assign w_mag = ({(2*W){i_sel.sel_one}}   & i_y1)
                 | ({(2*W){i_sel.sel_two}}   & i_y2)
                 | ({(2*W){i_sel.sel_three}} & i_y3)
                 | ({(2*W){i_sel.sel_four}}  & i_y4);

    // -M = ~M + 1; the +1 is handed to the carry-save tree as o_corr.
    assign o_pp   = i_sel.neg ? ~w_mag : w_mag;
    assign o_corr = i_sel.neg;

endmodule

// File: rtl/booth8_pipe_mul.sv
// -----------------------------------------------------------------------------
// booth8_pipe_mul
// Parametrised 3-stage pipelined radix-8 Booth multiplier, signed or unsigned
// per transaction, valid/ready handshake with full backpressure.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (in_ready combinational from out_ready)
//   in_x                 : multiplier (Booth-recoded)
//   in_y                 : multiplicand
//   in_signed            : 1 = two's complement operands, 0 = unsigned
//   out_valid / out_ready: result handshake
//   out_p                : 2W-bit exact product
// Stage 1 extends operands and forms 3Y; stage 2 builds partial products and
// reduces them to sum/carry; stage 3 performs the final add.
// -----------------------------------------------------------------------------
module booth8_pipe_mul
    import booth8_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_x,
    input  logic [W-1:0]   in_y,
    input  logic           in_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_p
);

    localparam int ND = nd(W);   // Booth digit count
    localparam int XW = 3 * ND;  // recoded multiplier width (>= W+1)
    localparam int PW = 2 * W;   // product width

    // ---------------------------------------------------------------- control
    logic w_adv;
    logic r_v1, r_v2, r_v3;

    // The whole pipe moves together: it advances whenever the output slot is
    // empty or being drained. Bubbles travel as empty stages.
    assign w_adv     = out_ready | ~r_v3;
    assign in_ready  = w_adv;
    assign out_valid = r_v3;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else if (w_adv) begin
            r_v1 <= in_valid;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
        end
    end

    // ---------------------------------------------------------------- stage 1
    logic          w_x_sgn, w_y_sgn;
    logic [XW-1:0] w_x_ext;
    logic [PW-1:0] w_y_ext, w_y3;
    logic [XW-1:0] r1_x;
    logic [PW-1:0] r1_y, r1_y3;

    // The mode bit is folded into the extension here, so it travels with its
    // operands and mixed-mode back-to-back traffic needs no extra state.
    assign w_x_sgn = in_signed & in_x[W-1];
    assign w_y_sgn = in_signed & in_y[W-1];
    assign w_x_ext = {{(XW-W){w_x_sgn}}, in_x};
    assign w_y_ext = {{(PW-W){w_y_sgn}}, in_y};
    assign w_y3    = w_y_ext + {w_y_ext[PW-2:0], 1'b0};

    // NOTE: datapath registers have no reset; their contents are only
    // consumed when the matching valid bit (which is reset) is set.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r1_x  <= w_x_ext;
            r1_y  <= w_y_ext;
            r1_y3 <= w_y3;
        end
    end

    // ---------------------------------------------------------------- stage 2
    logic [XW:0]   w_xz;
    logic [PW-1:0] w_y2, w_y4;
    booth_sel_t    w_sel [ND];
    logic [PW-1:0] w_pp  [ND];
    logic [ND-1:0] w_corr;

    // Implicit 0 below bit 0: digit i reads x'[3i+2:3i-1] = w_xz[3i+3:3i].
    assign w_xz = {r1_x, 1'b0};
    assign w_y2 = {r1_y[PW-2:0], 1'b0};
    assign w_y4 = {r1_y[PW-3:0], 2'b00};

    for (genvar i = 0; i < ND; i++) begin : g_digit
        assign w_sel[i] = booth8_enc(w_xz[3*i+3 -: 4]);

        booth8_pp_gen #(
            .W(W)
        ) u_pp_gen (
            .i_sel (w_sel[i]),
            .i_y1  (r1_y),
            .i_y2  (w_y2),
            .i_y3  (r1_y3),
            .i_y4  (w_y4),
            .o_pp  (w_pp[i]),
            .o_corr(w_corr[i])
        );
    end

    // Carry-save reduction. Correction bits sit at distinct positions 3i
    // (the low 3i bits of a shifted PP are zero), so they form one extra row
    // that seeds the sum vector; each PP row is then folded in by a 3:2 stage.
    logic [PW-1:0] w_cs_s, w_cs_c;

    // NOTE: every variable written here gets a value before any branch or
    // loop, so no latch can be inferred.
    always_comb begin
        logic [PW-1:0] w_row;
        logic [PW-1:0] w_sum;
        w_cs_s = '0;
        w_cs_c = '0;
        w_row  = '0;
        w_sum  = '0;
        for (int i = 0; i < ND; i++) begin
            w_cs_s[3*i] = w_corr[i];
        end
        for (int i = 0; i < ND; i++) begin
            w_row  = w_pp[i] << (3*i);
            w_sum  = w_cs_s ^ w_cs_c ^ w_row;
            w_cs_c = ((w_cs_s & w_cs_c) | (w_cs_s & w_row) | (w_cs_c & w_row)) << 1;
            w_cs_s = w_sum;
        end
    end

    logic [PW-1:0] r2_s, r2_c;

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r2_s <= w_cs_s;
            r2_c <= w_cs_c;
        end
    end

    // ---------------------------------------------------------------- stage 3
    logic [PW-1:0] r3_p;

    // Empty slots load zero so out_p never exposes stale datapath contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r3_p <= '0;
        end else if (w_adv) begin
            r3_p <= r_v2 ? (r2_s + r2_c) : '0;
        end
    end

    assign out_p = r3_p;

endmodule

// File: tb/tb_booth8_pipe_mul.sv
// -----------------------------------------------------------------------------
// tb_booth8_pipe_mul
// Scoreboard bench for booth8_pipe_mul at W=8 (directed + swept) and W=13
// (random). Expected products come from integer arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_booth8_pipe_mul;

    localparam int WA = 8;
    localparam int WB = 13;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // DUT A (W=8)
    logic            a_in_valid, a_in_ready, a_in_signed;
    logic [WA-1:0]   a_in_x, a_in_y;
    logic            a_out_valid, a_out_ready;
    logic [2*WA-1:0] a_out_p;

    // DUT B (W=13)
    logic            b_in_valid, b_in_ready, b_in_signed;
    logic [WB-1:0]   b_in_x, b_in_y;
    logic            b_out_valid, b_out_ready;
    logic [2*WB-1:0] b_out_p;

    booth8_pipe_mul #(.W(WA)) u_dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (a_in_valid),
        .in_ready (a_in_ready),
        .in_x     (a_in_x),
        .in_y     (a_in_y),
        .in_signed(a_in_signed),
        .out_valid(a_out_valid),
        .out_ready(a_out_ready),
        .out_p    (a_out_p)
    );

    booth8_pipe_mul #(.W(WB)) u_dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (b_in_valid),
        .in_ready (b_in_ready),
        .in_x     (b_in_x),
        .in_y     (b_in_y),
        .in_signed(b_in_signed),
        .out_valid(b_out_valid),
        .out_ready(b_out_ready),
        .out_p    (b_out_p)
    );

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_a[$];
    logic [63:0] exp_b[$];
    int a_ready_mode = 0;  // 0: always ready, 1: random, 2: held low

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: interpret operands as integers and multiply.
    function automatic logic [63:0] ref_mul(input int w, input logic [31:0] x,
                                            input logic [31:0] y, input bit s);
        longint mask, a, b;
        mask = (longint'(1) << w) - 1;
        a = longint'(x) & mask;
        b = longint'(y) & mask;
        if (s && x[w-1]) a = a - (longint'(1) << w);
        if (s && y[w-1]) b = b - (longint'(1) << w);
        return (a * b) & ((longint'(1) << (2*w)) - 1);
    endfunction

    // ------------------------------------------------------------ out_ready drivers
    initial begin
        a_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (a_ready_mode)
                0:       a_out_ready = 1'b1;
                1:       a_out_ready = ($urandom % 4) != 0;
                default: a_out_ready = 1'b0;
            endcase
        end
    end

    initial begin
        b_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            b_out_ready = ($urandom % 3) != 0;
        end
    end

    // ------------------------------------------------------------ monitors
    initial begin
        bit              prev_stall;
        logic [2*WA-1:0] prev_p;
        prev_stall = 1'b0;
        prev_p     = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall && a_out_valid) check("A stalled out_p stable", a_out_p, prev_p);
            if (a_out_valid && a_out_ready) begin
                if (exp_a.size() == 0) check("A unexpected output", a_out_valid, 0);
                else check("A product", a_out_p, exp_a.pop_front());
            end
            prev_stall = a_out_valid && !a_out_ready;
            prev_p     = a_out_p;
        end
    end

    initial begin
        bit              prev_stall;
        logic [2*WB-1:0] prev_p;
        prev_stall = 1'b0;
        prev_p     = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall && b_out_valid) check("B stalled out_p stable", b_out_p, prev_p);
            if (b_out_valid && b_out_ready) begin
                if (exp_b.size() == 0) check("B unexpected output", b_out_valid, 0);
                else check("B product", b_out_p, exp_b.pop_front());
            end
            prev_stall = b_out_valid && !b_out_ready;
            prev_p     = b_out_p;
        end
    end

    // ------------------------------------------------------------ stimulus tasks
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_a(input logic [WA-1:0] x, input logic [WA-1:0] y, input bit s);
        int n;
        n = 0;
        a_in_x = x; a_in_y = y; a_in_signed = s; a_in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!a_in_ready && n < 200);
        if (!a_in_ready) begin
            check("A accept timeout", a_in_ready, 1);
            a_in_valid = 1'b0;
            return;
        end
        exp_a.push_back(ref_mul(WA, 32'(x), 32'(y), s));
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [WB-1:0] x, input logic [WB-1:0] y, input bit s);
        int n;
        n = 0;
        b_in_x = x; b_in_y = y; b_in_signed = s; b_in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!b_in_ready && n < 200);
        if (!b_in_ready) begin
            check("B accept timeout", b_in_ready, 1);
            b_in_valid = 1'b0;
            return;
        end
        exp_b.push_back(ref_mul(WB, 32'(x), 32'(y), s));
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("A all results delivered", exp_a.size(), 0);
        check("B all results delivered", exp_b.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------ main sequence
    initial begin
        logic [WA-1:0] ys [8];
        int            n;
        ys = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd127, 8'd128, 8'd254, 8'd255};

        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_x = '0; a_in_y = '0; a_in_signed = 1'b0;
        b_in_valid = 1'b0; b_in_x = '0; b_in_y = '0; b_in_signed = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("A reset out_valid", a_out_valid, 0);
        check("A reset out_p", a_out_p, 0);
        check("B reset out_valid", b_out_valid, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Signed min*min and 3-cycle latency.
        send_a(8'h80, 8'h80, 1'b1);
        @(negedge clk); check("latency valid after 1", a_out_valid, 0);
        @(negedge clk); check("latency valid after 2", a_out_valid, 0);
        @(negedge clk); check("latency valid after 3", a_out_valid, 1);
        check("signed min*min", a_out_p, 16'h4000);
        @(posedge clk); #1;

        // Same bits, both modes.
        send_a(8'hFF, 8'hFF, 1'b0);
        send_a(8'hFF, 8'hFF, 1'b1);
        @(negedge clk);
        @(negedge clk); check("unsigned 255*255", a_out_p, 16'hFE01);
        @(negedge clk); check("signed -1*-1", a_out_p, 16'h0001);
        @(posedge clk); #1;

        // Alternating modes back to back.
        send_a(8'hFF, 8'd127, 1'b1);
        send_a(8'd200, 8'd3, 1'b0);
        send_a(8'd5, 8'hF9, 1'b1);
        @(negedge clk); check("mixed 1 valid", a_out_valid, 1); check("mixed 1", a_out_p, 16'hFF81);
        @(negedge clk); check("mixed 2 valid", a_out_valid, 1); check("mixed 2", a_out_p, 16'h0258);
        @(negedge clk); check("mixed 3 valid", a_out_valid, 1); check("mixed 3", a_out_p, 16'hFFDD);
        @(posedge clk); #1;

        // Backpressure: 6 pairs, 4-cycle output hold once out_valid rises.
        fork
            begin
                for (int j = 0; j < 6; j++)
                    send_a(WA'($urandom), WA'($urandom), 1'($urandom));
            end
            begin
                n = 0;
                do begin @(negedge clk); n++; end while (!a_out_valid && n < 50);
                check("BP out_valid rises", a_out_valid, 1);
                a_ready_mode = 2;
                @(posedge clk);
                repeat (4) begin
                    @(negedge clk);
                    check("BP in_ready low during hold", a_in_ready, 0);
                end
                a_ready_mode = 0;
            end
        join
        drain(100);

        // Reset while transactions are in flight and not yet emerged.
        send_a(8'd17, 8'd33, 1'b0);
        send_a(8'hF0, 8'd9, 1'b1);
        #2;
        rst_n = 1'b0;
        exp_a.delete();
        #1;
        check("flight reset out_valid", a_out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("no result after flight reset", a_out_valid, 0);
        end
        @(posedge clk); #1;
        send_a(8'd100, 8'hC3, 1'b1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); check("post-reset valid after 3", a_out_valid, 1);
        @(posedge clk); #1;
        drain(20);

        // Reset while a result is held at the output: valid drops immediately.
        a_ready_mode = 2;
        send_a(8'd77, 8'd3, 1'b0);
        n = 0;
        do begin @(negedge clk); n++; end while (!a_out_valid && n < 20);
        check("held result present", a_out_valid, 1);
        #1;
        rst_n = 1'b0;
        exp_a.delete();
        #1;
        check("async reset drops out_valid", a_out_valid, 0);
        check("async reset clears out_p", a_out_p, 0);
        @(negedge clk);
        rst_n = 1'b1;
        a_ready_mode = 1;
        @(posedge clk); #1;

        // Sweep: W=8 all x against corner y in both modes; W=13 random.
        fork
            begin
                for (int x = 0; x < 256; x++) begin
                    for (int k = 0; k < 8; k++) begin
                        for (int s = 0; s < 2; s++) begin
                            if ($urandom % 4 == 0) begin @(posedge clk); #1; end
                            send_a(WA'(x), ys[k], 1'(s));
                        end
                    end
                end
                for (int j = 0; j < 500; j++)
                    send_a(WA'($urandom), WA'($urandom), 1'($urandom));
            end
            begin
                send_b(13'h1000, 13'h1000, 1'b1);
                send_b(13'h1FFF, 13'h1FFF, 1'b0);
                send_b(13'h1FFF, 13'h1000, 1'b1);
                for (int j = 0; j < 3000; j++) begin
                    if ($urandom % 4 == 0) begin @(posedge clk); #1; end
                    send_b(WB'($urandom), WB'($urandom), 1'($urandom));
                end
            end
        join
        drain(2000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
